// File: rtl/c_fifo_tracker_shared.sv
// c_fifo_tracker_shared
//   Occupancy tracker for num_channels logical FIFOs sharing one buffer of
//   depth entries. Each channel owns `reserved` private entries; the rest of
//   the buffer is a common pool drawn on once a channel exceeds its reservation.
//   Drives per-channel flow-control flags for a router input port.
//
// Ports
//   clk_i            clock
//   reset_i          synchronous active-high reset (wins over active_i)
//   active_i         state-update enable
//   push_i/push_sel_i   one push per cycle, one-hot channel select
//   pop_i/pop_sel_i     one pop per cycle, one-hot channel select
//   empty_o, almost_empty_o, full_o, almost_full_o   per-channel flags (bit c = channel c)
//   occupancy_o      per-channel counts, channel 0 in the most significant slice
//   shared_free_o    unused pool entries
//   free_o           unused buffer entries
//   errors_o         per channel {underflow, overflow}, channel 0 in the top pair
module c_fifo_tracker_shared #(
  parameter int num_channels = 4,
  parameter int depth        = 16,
  parameter int reserved     = 2,
  localparam int shared      = depth - num_channels * reserved,
  localparam int max_occ     = reserved + shared,
  localparam int occ_width   = (max_occ < 1) ? 1 : $clog2(max_occ + 1),
  localparam int pool_width  = (shared < 1) ? 1 : $clog2(shared + 1),
  localparam int free_width  = (depth < 1) ? 1 : $clog2(depth + 1)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              active_i,
  input  logic                              push_i,
  input  logic [num_channels-1:0]           push_sel_i,
  input  logic                              pop_i,
  input  logic [num_channels-1:0]           pop_sel_i,
  output logic [num_channels-1:0]           empty_o,
  output logic [num_channels-1:0]           almost_empty_o,
  output logic [num_channels-1:0]           full_o,
  output logic [num_channels-1:0]           almost_full_o,
  output logic [num_channels*occ_width-1:0] occupancy_o,
  output logic [pool_width-1:0]             shared_free_o,
  output logic [free_width-1:0]             free_o,
  output logic [2*num_channels-1:0]         errors_o
);

  localparam logic [occ_width-1:0]  res_c    = occ_width'(reserved);
  localparam logic [occ_width-1:0]  max_c    = occ_width'(max_occ);
  localparam logic [pool_width-1:0] shared_c = pool_width'(shared);
  localparam logic [free_width-1:0] depth_c  = free_width'(depth);

  logic [occ_width-1:0]  occ_q [num_channels];
  logic [occ_width-1:0]  occ_d [num_channels];
  logic [pool_width-1:0] shared_used_q, shared_used_d;
  logic [free_width-1:0] free_q, free_d;

  logic [pool_width-1:0]   shared_free;
  logic                    pool_dry;
  logic [num_channels-1:0] ge_res, gt_res, empty_w, full_w, almost_full_w, almost_empty_w;
  logic [occ_width-1:0]    occ_inc [num_channels];
  logic [pool_width-1:0]   pool_after [num_channels];
  logic [num_channels-1:0] push_req, pop_req, same, push_do, pop_do, ovf, udf;
  logic                    su_inc, su_dec, push_any, pop_any;

  assign shared_free = shared_c - shared_used_q;
  assign pool_dry    = (shared_free == '0);

  // Flags depend on registered state only.
  always_comb begin
    for (int c = 0; c < num_channels; c++) begin
      ge_res[c]         = occ_q[c] >= res_c;
      gt_res[c]         = occ_q[c] > res_c;
      empty_w[c]        = occ_q[c] == '0;
      almost_empty_w[c] = occ_q[c] == occ_width'(1);
      full_w[c]         = (occ_q[c] == max_c) || (ge_res[c] && pool_dry);
      // occ_inc only matters when the channel is not full, so it cannot wrap.
      occ_inc[c]        = occ_q[c] + occ_width'(1);
      // A push at or above the reservation consumes one pool entry.
      pool_after[c]     = ge_res[c] ? (shared_free - pool_width'(1)) : shared_free;
      almost_full_w[c]  = ~full_w[c] &&
                          ((occ_inc[c] == max_c) ||
                           ((occ_inc[c] >= res_c) && (pool_after[c] == '0)));
    end
  end

  // Request decode. A push and pop on the same channel cancel and are always
  // legal; otherwise full/empty is judged on the current state only.
  always_comb begin
    push_req = {num_channels{push_i}} & push_sel_i;
    pop_req  = {num_channels{pop_i}} & pop_sel_i;
    same     = push_req & pop_req;
    push_do  = push_req & ~full_w & ~same;
    pop_do   = pop_req & ~empty_w & ~same;
    ovf      = push_req & full_w & ~pop_req;
    udf      = pop_req & empty_w & ~push_req;
    su_inc   = |(push_do & ge_res);
    su_dec   = |(pop_do & gt_res);
    push_any = |push_do;
    pop_any  = |pop_do;
  end

  always_comb begin
    for (int c = 0; c < num_channels; c++) begin
      occ_d[c] = occ_q[c] + occ_width'(push_do[c]) - occ_width'(pop_do[c]);
    end
    shared_used_d = shared_used_q;
    if (su_inc && !su_dec) shared_used_d = shared_used_q + pool_width'(1);
    if (!su_inc && su_dec) shared_used_d = shared_used_q - pool_width'(1);
    free_d = free_q;
    if (push_any && !pop_any) free_d = free_q - free_width'(1);
    if (!push_any && pop_any) free_d = free_q + free_width'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int c = 0; c < num_channels; c++) occ_q[c] <= '0;
      shared_used_q <= '0;
      free_q        <= depth_c;
    end else if (active_i) begin
      occ_q         <= occ_d;
      shared_used_q <= shared_used_d;
      free_q        <= free_d;
    end
  end

  always_comb begin
    occupancy_o = '0;
    errors_o    = '0;
    for (int c = 0; c < num_channels; c++) begin
      occupancy_o[(num_channels-1-c)*occ_width +: occ_width] = occ_q[c];
      errors_o[2*(num_channels-1-c)+1] = udf[c];
      errors_o[2*(num_channels-1-c)]   = ovf[c];
    end
  end

  assign empty_o        = empty_w;
  assign almost_empty_o = almost_empty_w;
  assign full_o         = full_w;
  assign almost_full_o  = almost_full_w;
  assign shared_free_o  = shared_free;
  assign free_o         = free_q;

endmodule

// File: tb/tb_c_fifo_tracker_shared.sv
module tb_c_fifo_tracker_shared;

  localparam int NC   = 4;
  localparam int DEP  = 16;
  localparam int RES  = 2;
  localparam int SHR  = DEP - NC * RES;
  localparam int MAXO = RES + SHR;

  typedef logic [40:0] snap_t;

  logic        clk, reset, active, push, pop;
  logic [3:0]  push_sel, pop_sel;
  logic [3:0]  empty, almost_empty, full, almost_full;
  logic [15:0] occupancy;
  logic [3:0]  shared_free;
  logic [4:0]  free;
  logic [7:0]  errors;

  int    chk_cnt  = 0;
  int    pass_cnt = 0;
  int    m_occ [NC];
  snap_t exp_q [$];

  c_fifo_tracker_shared #(.num_channels(NC), .depth(DEP), .reserved(RES)) dut (
    .clk_i(clk), .reset_i(reset), .active_i(active),
    .push_i(push), .push_sel_i(push_sel), .pop_i(pop), .pop_sel_i(pop_sel),
    .empty_o(empty), .almost_empty_o(almost_empty), .full_o(full),
    .almost_full_o(almost_full), .occupancy_o(occupancy),
    .shared_free_o(shared_free), .free_o(free), .errors_o(errors)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (push) assert ($onehot(push_sel));
    if (pop)  assert ($onehot(pop_sel));
  end

  // Reference model built from the flag definitions, not from counters.
  function automatic int m_su();
    int s = 0;
    for (int c = 0; c < NC; c++) if (m_occ[c] > RES) s += m_occ[c] - RES;
    return s;
  endfunction

  function automatic bit m_full(int c);
    return (m_occ[c] == MAXO) || (m_occ[c] >= RES && (SHR - m_su()) == 0);
  endfunction

  function automatic bit m_afull(int c);
    int sf1 = (m_occ[c] >= RES) ? SHR - m_su() - 1 : SHR - m_su();
    int o1  = m_occ[c] + 1;
    return !m_full(c) && ((o1 == MAXO) || (o1 >= RES && sf1 == 0));
  endfunction

  function automatic snap_t snap_model();
    logic [3:0]  e, ae, f, af;
    logic [15:0] o;
    int sum = 0;
    for (int c = 0; c < NC; c++) begin
      e[c]  = (m_occ[c] == 0);
      ae[c] = (m_occ[c] == 1);
      f[c]  = m_full(c);
      af[c] = m_afull(c);
      o[(NC-1-c)*4 +: 4] = 4'(m_occ[c]);
      sum += m_occ[c];
    end
    return {e, ae, f, af, o, 4'(SHR - m_su()), 5'(DEP - sum)};
  endfunction

  function automatic snap_t snap_dut();
    return {empty, almost_empty, full, almost_full, occupancy, shared_free, free};
  endfunction

  // Drives one cycle, samples errors mid-cycle, queues the expected post-edge state.
  task automatic drive(input bit rst, input bit act, input bit ps, input int pc,
                       input bit pp, input int qc,
                       output logic [7:0] got_err, output logic [7:0] exp_err);
    bit of, uf, pf, qe;
    @(negedge clk);
    reset    = rst;
    active   = act;
    push     = ps;
    push_sel = ps ? 4'(1 << pc) : 4'b0;
    pop      = pp;
    pop_sel  = pp ? 4'(1 << qc) : 4'b0;
    #1;
    got_err = errors;
    of = ps && m_full(pc) && !(pp && qc == pc);
    uf = pp && (m_occ[qc] == 0) && !(ps && pc == qc);
    exp_err = 8'b0;
    if (of) exp_err[2*(NC-1-pc)]   = 1'b1;
    if (uf) exp_err[2*(NC-1-qc)+1] = 1'b1;
    pf = m_full(pc);
    qe = (m_occ[qc] == 0);
    if (rst) begin
      for (int c = 0; c < NC; c++) m_occ[c] = 0;
    end else if (act && !(ps && pp && pc == qc)) begin
      if (ps && !pf) m_occ[pc]++;
      if (pp && !qe) m_occ[qc]--;
    end
    exp_q.push_back(snap_model());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] ge, ee;
    snap_t es;
    drive(1, 0, 0, 0, 0, 0, ge, ee);
    es = exp_q.pop_front();
    chk_cnt++; if (snap_dut() !== es) $display("FAIL reset_snap got %h exp %h", snap_dut(), es); else pass_cnt++;
    chk_cnt++; if (free !== 5'd16) $display("FAIL reset_free got %0d exp 16", free); else pass_cnt++;
    chk_cnt++; if (shared_free !== 4'd8) $display("FAIL reset_sfree got %0d exp 8", shared_free); else pass_cnt++;
    chk_cnt++; if ({empty, almost_empty, full, almost_full} !== 16'hF000)
      $display("FAIL reset_flags got %h exp F000", {empty, almost_empty, full, almost_full}); else pass_cnt++;
    chk_cnt++; if (errors !== 8'h00) $display("FAIL reset_errors got %h exp 00", errors); else pass_cnt++;
  endtask

  task automatic test_fill();
    logic [7:0] ge, ee;
    snap_t es;
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 1, 0, 0, 0, ge, ee);
      es = exp_q.pop_front();
      chk_cnt++; if (snap_dut() !== es) $display("FAIL fill_snap%0d got %h exp %h", i, snap_dut(), es); else pass_cnt++;
      chk_cnt++; if (occupancy[15:12] !== 4'(i + 1)) $display("FAIL fill_occ0 got %0d exp %0d", occupancy[15:12], i + 1); else pass_cnt++;
      chk_cnt++; if (almost_full[0] !== (i == 8)) $display("FAIL fill_af0 step %0d got %b", i, almost_full[0]); else pass_cnt++;
      chk_cnt++; if (full[0] !== (i == 9)) $display("FAIL fill_full0 step %0d got %b", i, full[0]); else pass_cnt++;
    end
    chk_cnt++; if (shared_free !== 4'd0) $display("FAIL fill_sfree got %0d exp 0", shared_free); else pass_cnt++;
    chk_cnt++; if (free !== 5'd6) $display("FAIL fill_free got %0d exp 6", free); else pass_cnt++;
  endtask

  task automatic test_pool_exhaustion();
    logic [7:0] ge, ee;
    snap_t es;
    drive(1, 1, 0, 0, 0, 0, ge, ee);
    void'(exp_q.pop_front());
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 1, 1, 0, 0, ge, ee);
      es = exp_q.pop_front();
      chk_cnt++; if (snap_dut() !== es) $display("FAIL pool_ch1_snap%0d got %h exp %h", i, snap_dut(), es); else pass_cnt++;
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 2, 0, 0, ge, ee);
      chk_cnt++; if (ge !== ee) $display("FAIL pool_err%0d got %h exp %h", i, ge, ee); else pass_cnt++;
      chk_cnt++; if (ge !== ((i == 2) ? 8'h04 : 8'h00)) $display("FAIL pool_ovf%0d got %h", i, ge); else pass_cnt++;
      es = exp_q.pop_front();
      chk_cnt++; if (snap_dut() !== es) $display("FAIL pool_ch2_snap%0d got %h exp %h", i, snap_dut(), es); else pass_cnt++;
      if (i == 0) begin
        chk_cnt++; if (almost_full[2] !== 1'b1) $display("FAIL pool_af2 got %b exp 1", almost_full[2]); else pass_cnt++;
      end
    end
    chk_cnt++; if (occupancy[7:4] !== 4'd2 || full[2] !== 1'b1)
      $display("FAIL pool_occ2 got occ %0d full %b exp 2 1", occupancy[7:4], full[2]); else pass_cnt++;
  endtask

  task automatic test_cross_channel();
    logic [7:0] ge, ee;
    snap_t es;
    drive(0, 1, 1, 2, 1, 1, ge, ee);
    chk_cnt++; if (ge !== 8'h04) $display("FAIL cross_err got %h exp 04", ge); else pass_cnt++;
    es = exp_q.pop_front();
    chk_cnt++; if (snap_dut() !== es) $display("FAIL cross_snap got %h exp %h", snap_dut(), es); else pass_cnt++;
    chk_cnt++; if ({occupancy[11:8], occupancy[7:4], shared_free} !== 12'h921)
      $display("FAIL cross_state got %h exp 921", {occupancy[11:8], occupancy[7:4], shared_free}); else pass_cnt++;
    chk_cnt++; if (full[2] !== 1'b0) $display("FAIL cross_full2 got %b exp 0", full[2]); else pass_cnt++;
  endtask

  task automatic test_same_channel();
    logic [7:0] ge, ee;
    snap_t es;
    drive(1, 1, 0, 0, 0, 0, ge, ee);
    void'(exp_q.pop_front());
    drive(0, 1, 1, 0, 1, 0, ge, ee);
    chk_cnt++; if (ge !== 8'h00) $display("FAIL same_empty_err got %h exp 00", ge); else pass_cnt++;
    es = exp_q.pop_front();
    chk_cnt++; if (snap_dut() !== es || occupancy[15:12] !== 4'd0)
      $display("FAIL same_empty_snap got %h exp %h", snap_dut(), es); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 1, 0, 0, 0, ge, ee);
      void'(exp_q.pop_front());
    end
    drive(0, 1, 1, 0, 1, 0, ge, ee);
    chk_cnt++; if (ge !== 8'h00) $display("FAIL same_full_err got %h exp 00", ge); else pass_cnt++;
    es = exp_q.pop_front();
    chk_cnt++; if (snap_dut() !== es || occupancy[15:12] !== 4'd10)
      $display("FAIL same_full_snap got %h exp %h", snap_dut(), es); else pass_cnt++;
  endtask

  task automatic test_underflow();
    logic [7:0] ge, ee;
    snap_t es;
    drive(1, 1, 0, 0, 0, 0, ge, ee);
    void'(exp_q.pop_front());
    drive(0, 1, 0, 0, 1, 3, ge, ee);
    chk_cnt++; if (ge !== 8'h02) $display("FAIL udf_err got %h exp 02", ge); else pass_cnt++;
    es = exp_q.pop_front();
    chk_cnt++; if (snap_dut() !== es || free !== 5'd16)
      $display("FAIL udf_state got %h exp %h", snap_dut(), es); else pass_cnt++;
  endtask

  task automatic test_active_reset();
    logic [7:0] ge, ee;
    snap_t es;
    drive(1, 1, 0, 0, 0, 0, ge, ee);
    void'(exp_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 1, 0, 0, ge, ee);
      void'(exp_q.pop_front());
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 1, 0, 0, ge, ee);
      es = exp_q.pop_front();
      chk_cnt++; if (snap_dut() !== es || occupancy[11:8] !== 4'd3)
        $display("FAIL hold%0d got %h exp %h", i, snap_dut(), es); else pass_cnt++;
    end
    drive(0, 1, 1, 1, 0, 0, ge, ee);
    void'(exp_q.pop_front());
    drive(1, 1, 1, 1, 0, 0, ge, ee);
    es = exp_q.pop_front();
    chk_cnt++; if (snap_dut() !== es || occupancy !== 16'h0 || free !== 5'd16 || shared_free !== 4'd8)
      $display("FAIL midreset got %h exp %h", snap_dut(), es); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [7:0] ge, ee;
    snap_t es;
    bit ps, pp, act;
    int pc, qc;
    drive(1, 1, 0, 0, 0, 0, ge, ee);
    void'(exp_q.pop_front());
    for (int i = 0; i < 300; i++) begin
      ps  = ($urandom_range(0, 99) < ((i < 150) ? 70 : 35));
      pp  = ($urandom_range(0, 99) < ((i < 150) ? 35 : 70));
      pc  = $urandom_range(0, NC - 1);
      qc  = $urandom_range(0, NC - 1);
      act = ($urandom_range(0, 7) != 0);
      drive(0, act, ps, pc, pp, qc, ge, ee);
      chk_cnt++; if (ge !== ee) $display("FAIL rand_err%0d got %h exp %h", i, ge, ee); else pass_cnt++;
      es = exp_q.pop_front();
      chk_cnt++; if (snap_dut() !== es) $display("FAIL rand_snap%0d got %h exp %h", i, snap_dut(), es); else pass_cnt++;
    end
  endtask

  initial begin
    reset = 1'b1; active = 1'b0; push = 1'b0; pop = 1'b0;
    push_sel = 4'b0; pop_sel = 4'b0;
    for (int c = 0; c < NC; c++) m_occ[c] = 0;
    test_reset();
    test_fill();
    test_pool_exhaustion();
    test_cross_channel();
    test_same_channel();
    test_underflow();
    test_active_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/c_fifo_tracker_shared.md
# c_fifo_tracker_shared

Tracks occupancy of `num_channels` logical FIFOs that share one physical buffer of `depth` entries. Each channel has `reserved` private entries. The rest of the buffer (`depth - num_channels*reserved`) is a common shared pool. The block sits on the credit/input-buffer side of a router port, beside the shared buffer RAM, and drives the per-channel full/empty flags used by flow control and allocation. It accepts at most one push and one pop per cycle, to the same or different channels.

## Interface
- `num_channels`, 4: number of logical FIFOs (≥1).
- `depth`, 16: total buffer entries. Must satisfy `depth ≥ num_channels*reserved` and `depth ≥ 1`.
- `reserved`, 2: private entries per channel (≥0).
- Derived: `shared = depth - num_channels*reserved`; `max_occ = reserved + shared`; `occ_width = clogb(max_occ+1)`; `pool_width = clogb(shared+1)`; `free_width = clogb(depth+1)`.
- `clk`  in  1  clock; single clock domain.
- `reset`  in  1  reset; synchronous, active-high.
- `active`  in  1  state-update enable; when low, all registers hold.
- `push`  in  1  add one entry to the channel selected by `push_sel`.
- `push_sel`  in  num_channels  one-hot target channel for push.
- `pop`  in  1  remove one entry from the channel selected by `pop_sel`.
- `pop_sel`  in  num_channels  one-hot target channel for pop.
- `empty`  out  num_channels  channel occupancy == 0.
- `almost_empty`  out  num_channels  channel occupancy == 1.
- `full`  out  num_channels  channel cannot accept a push.
- `almost_full`  out  num_channels  channel not full, but full after one more push with no pop.
- `occupancy`  out  num_channels*occ_width  per-channel entry count, channel 0 in the most significant slice.
- `shared_free`  out  pool_width  unused shared-pool entries.
- `free`  out  free_width  total unused buffer entries.
- `errors`  out  2*num_channels  per channel {underflow, overflow}, channel 0 first.

## Operation
- **State registers:**
  - `occ[c]` per channel.
  - `shared_used`, which always equals Σ max(0, `occ[c]` − `reserved`).
- **Per-channel fill order:** `occ` below `reserved` uses private entries. Entries beyond `reserved` draw on the shared pool.
- **Derived values:**
  - `shared_free = shared − shared_used`.
  - `free = depth − Σ occ`. Maintain `free` as a register updated incrementally; do not use an adder tree.
- **full[c]:**
  - asserted when `occ[c] == max_occ`, or
  - when `occ[c] ≥ reserved` and `shared_free == 0`.
- **almost_full[c]:** `~full[c]`, and the post-push state would satisfy the `full` condition. Post-push state is `occ+1`, and `shared_free−1` if the push draws on the pool.
- **Push to c (effective):**
  - `occ[c]+1`.
  - If the old `occ[c] ≥ reserved`, also `shared_used+1`.
  - `free−1`.
- **Pop from c (effective):**
  - `occ[c]−1`.
  - If the old `occ[c] > reserved`, also `shared_used−1`.
  - `free+1`.
- **Push and pop on the same channel:** `occ`, `shared_used` and `free` are unchanged. This is legal even when the channel is full or empty.
- **Push and pop on different channels:** both updates apply. When the pop frees a pool entry and the push takes one, `shared_used` is unchanged. Full status is evaluated on current state, so a push to a pool-full channel is an overflow even if a simultaneous pop on another channel frees a pool entry.
- **Overflow[c]:** `push & push_sel[c] & full[c] & ~(pop & pop_sel[c])`. The push is dropped and state is unchanged for that operation.
- **Underflow[c]:** `pop & pop_sel[c] & empty[c] & ~(push & push_sel[c])`. The pop is dropped.
- **Select vectors:** `push_sel`/`pop_sel` are ignored when `push`/`pop` is low. Non-one-hot selects while valid are illegal; the bench asserts they never occur.

## Timing
- All state updates on the rising `clk` edge when `active=1`. Results are visible the next cycle.
- `empty`, `almost_empty`, `full`, `almost_full`, `occupancy`, `shared_free` and `free` are combinational functions of registered state only. There is no combinational path from push/pop.
- `errors` is combinational from the current inputs and state, in the same cycle as the offending request.
- **Reset:**
  - Reset is applied on the clock edge regardless of `active`.
  - State after reset: `occ=0`, `shared_used=0`, `free=depth`.
  - Outputs after reset: `empty=all 1`, `almost_empty=0`, `full=0` (`full[c]=1` only if `max_occ==0`), `almost_full[c]=(max_occ==1)`, `shared_free=shared`, `errors=0`.
- **Reset mid-operation:** reset discards any push/pop in the same cycle.
- **Degenerate parameters:**
  - `reserved=0`: a pure shared pool.
  - `shared=0`: a static partition. `full[c]` is asserted at `occ==reserved`.

## Test plan
- **Reset and fill:** after reset, push ch0 ten times → `occ0` 1..10. `full[0]` rises after the 10th push, `almost_full[0]` after the 9th. `shared_free=0`, `free=6`.
- **Pool exhaustion:** from reset, push ch1 ×10, then push ch2 ×3. ch2 reaches `occ=2` and `full[2]=1`; the 3rd push flags `errors` overflow[2] with `occ2` staying 2. `almost_full[2]` is set at `occ2=1`.
- **Simultaneous cross-channel:** with ch1 at 10 and ch2 at 2 (both full), push ch2 and pop ch1 in one cycle → overflow[2] is flagged and the push is dropped. Next cycle `occ1=9`, `occ2=2`, `shared_free=1`, `full[2]=0`.
- **Same-channel push+pop:** with ch0 empty, push+pop ch0 → no error and `occ0` stays 0. Repeat with ch0 full → no error and `occ` unchanged.
- **Underflow:** pop ch3 at reset → underflow[3]=1 for that cycle; state unchanged, `free=16`.
- **active and reset:** hold `active=0` for 5 cycles with pushes → state frozen. Assert `reset` mid-fill with a push pending → next cycle all counters are at reset values.
